// File: rtl/traffic_pkg.sv
// Shared colour and state encodings for the highway/country signal controller,
// plus the state-to-lamp decode used by the registered outputs.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5,
    WK  = 3'd6
  } state_t;

  // Returns {hwy, cntry}; any unknown code shows highway green as the safe default.
  function automatic logic [3:0] lamps(input logic [2:0] s);
    case (s)
      HG:           lamps = {GREEN, RED};
      HY:           lamps = {YELLOW, RED};
      CG:           lamps = {RED, GREEN};
      CY:           lamps = {RED, YELLOW};
      AR1, AR2, WK: lamps = {RED, RED};
      default:      lamps = {GREEN, RED};
    endcase
  endfunction

endpackage

// File: rtl/traffic_signal_controller_param_dwell_timer.sv
// Saturating dwell down-counter: loads on request, counts to zero and holds there.
// The reset value is a parameter so the first phase after clear is already timed.
module dwell_timer #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/traffic_signal_controller_param.sv
// Two-road signal controller with parametrised dwell times and all-red clearance phases.
// Define PED_WALK_EN to add the pedestrian request input, walk output and WK phase.
module traffic_signal_controller_param
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned Y2R_CYC       = 3,
  parameter int unsigned R2G_CYC       = 2,
  parameter int unsigned HWY_MIN_CYC   = 4,
  parameter int unsigned CNTRY_MAX_CYC = 10,
  parameter int unsigned WALK_CYC      = 5
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       X,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] state_o
`ifdef PED_WALK_EN
  ,
  input  logic       ped_req,
  output logic       walk
`endif
);

  localparam logic [CNT_W-1:0] HwyMinM1   = CNT_W'(HWY_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] Y2rM1      = CNT_W'(Y2R_CYC - 1);
  localparam logic [CNT_W-1:0] R2gM1      = CNT_W'(R2G_CYC - 1);
  localparam logic [CNT_W-1:0] CntryMaxM1 = CNT_W'(CNTRY_MAX_CYC - 1);
  localparam logic [CNT_W-1:0] WalkM1     = CNT_W'(WALK_CYC - 1);

  // Timer reload value on entry to a state: its dwell minus one.
  function automatic logic [CNT_W-1:0] dwell_m1(input state_t s);
    case (s)
      HG:       dwell_m1 = HwyMinM1;
      HY, CY:   dwell_m1 = Y2rM1;
      AR1, AR2: dwell_m1 = R2gM1;
      CG:       dwell_m1 = CntryMaxM1;
      WK:       dwell_m1 = WalkM1;
      default:  dwell_m1 = HwyMinM1;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic             expired;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             ped_pend;

`ifdef PED_WALK_EN
  logic ped_pend_q, ped_pend_d;
  assign ped_pend = ped_pend_q;
`else
  assign ped_pend = 1'b0;
`endif

  dwell_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (HwyMinM1)
  ) u_dwell_timer (
    .clock    (clock),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      HG:  if (expired && (X || ped_pend)) state_d = HY;
      HY:  if (expired) state_d = AR1;
      AR1: if (expired) state_d = CG;
      // Country green ends at once when the car leaves, else at the max-green limit.
      CG:  if (!X || expired) state_d = CY;
      CY:  if (expired) state_d = AR2;
      AR2: if (expired) state_d = ped_pend ? WK : HG;
`ifdef PED_WALK_EN
      WK:  if (expired) state_d = HG;
`endif
      default: state_d = HG;
    endcase
  end

  // Any state change reloads the timer in the same edge that commits the state.
  always_comb begin
    load     = (state_d != state_q);
    load_val = dwell_m1(state_d);
  end

`ifdef PED_WALK_EN
  // A request in the same cycle as WK entry wins over the clear.
  always_comb begin
    ped_pend_d = ((state_d == WK && state_q != WK) ? 1'b0 : ped_pend_q) | ped_req;
  end
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= HG;
      hwy     <= GREEN;
      cntry   <= RED;
`ifdef PED_WALK_EN
      ped_pend_q <= 1'b0;
      walk       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      {hwy, cntry}   <= lamps(state_d);
`ifdef PED_WALK_EN
      ped_pend_q <= ped_pend_d;
      walk       <= (state_d == WK);
`endif
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_signal_controller_param.sv
// Scoreboard bench: per-cycle expected state/lamps are queued with the X value to drive,
// then popped and compared on each falling edge.
module tb_traffic_signal_controller_param;

  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;

  localparam logic [2:0] S_HG  = 3'd0;
  localparam logic [2:0] S_HY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_CG  = 3'd3;
  localparam logic [2:0] S_CY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       X     = 1'b0;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic [2:0] state_o;
`ifdef PED_WALK_EN
  logic       ped_req = 1'b0;
  logic       walk;
`endif

  traffic_signal_controller_param dut (
    .clock   (clock),
    .clear   (clear),
    .X       (X),
    .hwy     (hwy),
    .cntry   (cntry),
    .state_o (state_o)
`ifdef PED_WALK_EN
    ,
    .ped_req (ped_req),
    .walk    (walk)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       x;
    logic [2:0] st;
    logic [1:0] h;
    logic [1:0] c;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   sample   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s sample=%0d got=%0d exp=%0d", tag, sample, got, exp);
    end
  endtask

  task automatic push(input int n, input logic x, input logic [2:0] st,
                      input logic [1:0] h, input logic [1:0] c);
    exp_t e;
    e.x  = x;
    e.st = st;
    e.h  = h;
    e.c  = c;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic run();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("state", int'(state_o), int'(e.st));
      check_eq("hwy", int'(hwy), int'(e.h));
      check_eq("cntry", int'(cntry), int'(e.c));
      check_eq("safe", int'(hwy == RED || cntry == RED), 1);
      X = e.x;
      sample++;
      @(negedge clock);
    end
  endtask

  // Called on a falling edge: clear rises mid-cycle and must act before any clock edge.
  task automatic pulse_reset();
    #2 clear = 1'b1;
    #1;
    check_eq("arst_hwy", int'(hwy), int'(GRN));
    check_eq("arst_cntry", int'(cntry), int'(RED));
    check_eq("arst_state", int'(state_o), int'(S_HG));
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sample=%0d", sample);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b1;
    X     = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_hwy", int'(hwy), int'(GRN));
    check_eq("rst_cntry", int'(cntry), int'(RED));
    check_eq("rst_state", int'(state_o), int'(S_HG));
    clear = 1'b0;

    // Idle, then a late request is honoured immediately; full max-green cycle.
    push(50, 1'b0, S_HG,  GRN, RED);
    push(1,  1'b1, S_HG,  GRN, RED);
    push(3,  1'b1, S_HY,  YEL, RED);
    push(2,  1'b1, S_AR1, RED, RED);
    push(10, 1'b1, S_CG,  RED, GRN);
    push(3,  1'b0, S_CY,  RED, YEL);
    push(2,  1'b0, S_AR2, RED, RED);
    push(5,  1'b0, S_HG,  GRN, RED);
    run();

    // X high from the first cycle after reset; X pulses in CY/AR2 must not latch.
    pulse_reset();
    push(4,  1'b1, S_HG,  GRN, RED);
    push(3,  1'b1, S_HY,  YEL, RED);
    push(2,  1'b1, S_AR1, RED, RED);
    push(10, 1'b1, S_CG,  RED, GRN);
    push(3,  1'b1, S_CY,  RED, YEL);
    push(2,  1'b1, S_AR2, RED, RED);
    push(6,  1'b0, S_HG,  GRN, RED);
    // Early country release: CG lasts 3 cycles.
    push(1,  1'b1, S_HG,  GRN, RED);
    push(3,  1'b1, S_HY,  YEL, RED);
    push(2,  1'b1, S_AR1, RED, RED);
    push(2,  1'b1, S_CG,  RED, GRN);
    push(1,  1'b0, S_CG,  RED, GRN);
    push(3,  1'b0, S_CY,  RED, YEL);
    push(2,  1'b0, S_AR2, RED, RED);
    push(4,  1'b1, S_HG,  GRN, RED);
    push(2,  1'b1, S_HY,  YEL, RED);
    run();

    // Reset in the third HY cycle: no yellow completion, timer reloaded.
    pulse_reset();
    push(4,  1'b1, S_HG,  GRN, RED);
    push(3,  1'b0, S_HY,  YEL, RED);
    push(2,  1'b0, S_AR1, RED, RED);
    push(1,  1'b0, S_CG,  RED, GRN);
    push(3,  1'b0, S_CY,  RED, YEL);
    push(2,  1'b0, S_AR2, RED, RED);
    push(3,  1'b0, S_HG,  GRN, RED);
    run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
